// File: rtl/ndro_pulse_checker.sv
// NDRO cell pulse checker: tracks expected state, times read windows,
// counts good reads and errors. Macro NDRO_CHK_SPURIOUS_EN adds spurious-out detection.
module ndro_pulse_checker #(
  parameter int WINDOW = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_p,
  input  logic             rst_p,
  input  logic             clk_p,
  input  logic             out_p,
  output logic             exp_state,
  output logic             busy,
  output logic             err_flag,
  output logic [1:0]       last_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] rd_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [3:0] TLAST = 4'(WINDOW - 1);
  localparam logic [ERR_W+1:0] SAT =
    (ERR_W+2)'({ERR_W{1'b1}});

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       timer;
  logic [3:0]       timer_nxt;
  logic             exp_nxt;
  logic [1:0]       n_err;
  logic [1:0]       code_nxt;
  logic             rd_inc;
  logic             spur;
  logic [ERR_W+1:0] esum;
  logic [ERR_W+1:0] rsum;
  logic [ERR_W-1:0] err_nxt;
  logic [ERR_W-1:0] rd_nxt;

`ifdef NDRO_CHK_SPURIOUS_EN
  assign spur = (state == IDLE) && out_p;
`else
  assign spur = 1'b0;
`endif

  assign busy = (state == WAIT);

  // Saturating counter updates; two errors may land in one cycle.
  always_comb begin
    esum = {2'b00, err_cnt} + (ERR_W+2)'(n_err);
    rsum = {2'b00, rd_cnt} + (ERR_W+2)'(rd_inc);
    err_nxt = (esum > SAT) ? SAT[ERR_W-1:0]
                           : esum[ERR_W-1:0];
    rd_nxt  = (rsum > SAT) ? SAT[ERR_W-1:0]
                           : rsum[ERR_W-1:0];
  end

  // Next state, window timer, error and read decisions.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    n_err     = 2'd0;
    code_nxt  = last_err;
    rd_inc    = 1'b0;
    exp_nxt   = rst_p ? 1'b0 : (set_p ? 1'b1 : exp_state);
    unique case (state)
      IDLE: begin
        if (clk_p && exp_state) begin
          state_nxt = WAIT;
          timer_nxt = 4'd0;
        end else if (clk_p) begin
          rd_inc = 1'b1;
        end
        if (spur) begin
          n_err    = 2'd1;
          code_nxt = 2'd3;
        end
      end
      WAIT: begin
        timer_nxt = timer + 4'd1;
        if (clk_p) begin
          n_err    = 2'd1;
          code_nxt = 2'd2;
        end
        if (out_p) begin
          rd_inc    = 1'b1;
          state_nxt = IDLE;
          timer_nxt = 4'd0;
        end else if (timer == TLAST) begin
          n_err     = n_err + 2'd1;
          code_nxt  = 2'd1;
          state_nxt = IDLE;
          timer_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending window silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= 4'd0;
      exp_state <= 1'b0;
      err_flag  <= 1'b0;
      last_err  <= 2'd0;
      err_cnt   <= '0;
      rd_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      exp_state <= exp_nxt;
      err_flag  <= err_flag | (n_err != 2'd0);
      last_err  <= code_nxt;
      err_cnt   <= err_nxt;
      rd_cnt    <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_ndro_pulse_checker.sv
// Directed bench for ndro_pulse_checker (WINDOW=4, ERR_W=2).
// Expected outputs are queued per drive and popped per edge.
module tb_ndro_pulse_checker;

  localparam int WIN = 4;
  localparam int EW  = 2;
  localparam int MAXC = (1 << EW) - 1;

`ifdef NDRO_CHK_SPURIOUS_EN
  localparam bit SPUR = 1'b1;
`else
  localparam bit SPUR = 1'b0;
`endif

  typedef struct packed {
    logic          exp_state;
    logic          busy;
    logic          err_flag;
    logic [1:0]    last_err;
    logic [EW-1:0] err_cnt;
    logic [EW-1:0] rd_cnt;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_p = 1'b0;
  logic rst_p = 1'b0;
  logic clk_p = 1'b0;
  logic out_p = 1'b0;
  logic exp_state;
  logic busy;
  logic err_flag;
  logic [1:0] last_err;
  logic [EW-1:0] err_cnt;
  logic [EW-1:0] rd_cnt;

  int tests = 0;
  int fails = 0;
  int busy_cycles = 0;

  obs_t sb[$];

  bit m_wait;
  int m_tmr;
  bit m_exp;
  bit m_flag;
  int m_last;
  int m_err;
  int m_rd;

  ndro_pulse_checker #(.WINDOW(WIN), .ERR_W(EW)) dut (
    .clk(clk),
    .reset(reset),
    .set_p(set_p),
    .rst_p(rst_p),
    .clk_p(clk_p),
    .out_p(out_p),
    .exp_state(exp_state),
    .busy(busy),
    .err_flag(err_flag),
    .last_err(last_err),
    .err_cnt(err_cnt),
    .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t cur_obs();
    obs_t o;
    o.exp_state = exp_state;
    o.busy      = busy;
    o.err_flag  = err_flag;
    o.last_err  = last_err;
    o.err_cnt   = err_cnt;
    o.rd_cnt    = rd_cnt;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.exp_state = m_exp;
    o.busy      = m_wait;
    o.err_flag  = m_flag;
    o.last_err  = 2'(m_last);
    o.err_cnt   = EW'(m_err);
    o.rd_cnt    = EW'(m_rd);
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_tmr = 0; m_exp = 0; m_flag = 0;
    m_last = 0; m_err = 0; m_rd = 0;
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_step(input bit s, input bit r,
                            input bit c, input bit o);
    int ne;
    ne = 0;
    if (!m_wait) begin
      if (c && m_exp) begin
        m_wait = 1; m_tmr = 0;
      end else if (c) begin
        m_rd = m_rd + 1;
      end
      if (o && SPUR) begin
        ne = 1; m_last = 3;
      end
    end else begin
      if (c) begin
        ne = ne + 1; m_last = 2;
      end
      if (o) begin
        m_rd = m_rd + 1; m_wait = 0;
      end else if (m_tmr == WIN - 1) begin
        ne = ne + 1; m_last = 1; m_wait = 0;
      end else begin
        m_tmr = m_tmr + 1;
      end
    end
    if (ne > 0) m_flag = 1;
    m_err = m_err + ne;
    if (m_err > MAXC) m_err = MAXC;
    if (m_rd > MAXC) m_rd = MAXC;
    if (r) m_exp = 0;
    else if (s) m_exp = 1;
  endtask

  task automatic step(input bit s, input bit r,
                      input bit c, input bit o);
    obs_t want;
    obs_t got;
    @(negedge clk);
    reset = 1'b0;
    set_p = s; rst_p = r; clk_p = c; out_p = o;
    model_step(s, r, c, o);
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
    set_p = 0; rst_p = 0; clk_p = 0; out_p = 0;
    got = cur_obs();
    if (got.busy) busy_cycles++;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      want = sb.pop_front();
      check("cycle", 32'(got), 32'(want));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    set_p = 0; rst_p = 0; clk_p = 0; out_p = 0;
    #1;
    model_reset();
    check(tag, 32'(cur_obs()), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_hold"}, 32'(cur_obs()), 32'd0);
    busy_cycles = 0;
  endtask

  initial begin
    model_reset();
    #2;
    check("por", 32'(cur_obs()), 32'd0);
    do_reset("rst0");

    // good read: set, clk 3 later, out 2 after clk
    step(1, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(2);
    check("s35_rd", 32'(rd_cnt), 32'd1);
    check("s35_err", 32'(err_cnt), 32'd0);
    check("s35_busy", 32'(busy_cycles), 32'd2);

    // miss error lands 4 cycles after clk
    do_reset("rst1");
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle(3);
    check("s36_pre", 32'(err_flag), 32'd0);
    idle(1);
    check("s36_err", 32'(err_cnt), 32'd1);
    check("s36_last", 32'(last_err), 32'd1);
    check("s36_flag", 32'(err_flag), 32'd1);
    check("s36_busy", 32'(busy), 32'd0);

    // set and reset together: reset wins
    do_reset("rst2");
    step(1, 1, 0, 0);
    check("s37_exp", 32'(exp_state), 32'd0);
    step(0, 0, 1, 0);
    check("s37_busy", 32'(busy), 32'd0);
    check("s37_rd", 32'(rd_cnt), 32'd1);
    check("s37_err", 32'(err_cnt), 32'd0);

    // overrun clk during window, then good out
    do_reset("rst3");
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check("s38_err", 32'(err_cnt), 32'd1);
    check("s38_last", 32'(last_err), 32'd2);
    check("s38_rd", 32'(rd_cnt), 32'd1);

    // out in idle
    do_reset("rst4");
    step(0, 0, 0, 1);
    check("s39_err", 32'(err_cnt), SPUR ? 32'd1 : 32'd0);
    check("s39_last", 32'(last_err), SPUR ? 32'd3 : 32'd0);

    // out at last window cycle is still accepted
    do_reset("rst5");
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle(3);
    step(0, 0, 0, 1);
    check("edge_rd", 32'(rd_cnt), 32'd1);
    check("edge_err", 32'(err_cnt), 32'd0);

    // overrun and miss in the same cycle
    do_reset("rst6");
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle(3);
    step(0, 0, 1, 0);
    check("dbl_err", 32'(err_cnt), 32'd2);
    check("dbl_last", 32'(last_err), 32'd1);

    // out in same cycle as entering clk, then accepted out
    do_reset("rst7");
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    check("co_busy", 32'(busy), 32'd1);
    step(0, 0, 0, 1);
    check("co_rd", 32'(rd_cnt), 32'd1);
    check("co_err", 32'(err_cnt), SPUR ? 32'd1 : 32'd0);

    // clear state mid-scenario with rst_p then read in idle
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("rp_rd", 32'(rd_cnt), 32'd2);

    // five misses saturate err_cnt, then reset mid-wait
    do_reset("rst8");
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0);
      idle(WIN);
    end
    check("sat_err", 32'(err_cnt), 32'(MAXC));
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("sat_busy", 32'(busy), 32'd1);
    do_reset("rst_mid");
    idle(WIN + 2);
    check("post_err", 32'(err_cnt), 32'd0);
    check("post_flag", 32'(err_flag), 32'd0);

    // rd_cnt saturation with idle reads
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0);
    check("rd_sat", 32'(rd_cnt), 32'(MAXC));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
